// File: rtl/regfile_sb_pkg.sv
// Shared defaults and width helpers for the scoreboarded register file.
package regfile_sb_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_NREG     = 32;
    localparam int DEF_NRD      = 2;
    localparam int DEF_MAX_INFL = 3;
    localparam int REG_ZERO     = 0;

    function automatic int calc_aw(input int nreg);
        return $clog2(nreg);
    endfunction

    function automatic int calc_cw(input int max_infl);
        return $clog2(max_infl + 1);
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, issue and writeback bundle between the pipeline and the register file.
interface regfile_sb_if
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREG   = DEF_NREG,
    parameter int NRD    = DEF_NRD
) ();
    localparam int AW = calc_aw(NREG);

    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_pend;
    logic                  iss_valid;
    logic [AW-1:0]         iss_dest;
    logic                  iss_ready;
    logic                  wb_valid;
    logic [AW-1:0]         wb_dest;
    logic [DATA_W-1:0]     wb_data;
    logic                  idle;
    logic                  sb_err;

    modport master (
        output rd_addr, iss_valid, iss_dest, wb_valid, wb_dest, wb_data,
        input  rd_data, rd_pend, iss_ready, idle, sb_err
    );

    modport slave (
        input  rd_addr, iss_valid, iss_dest, wb_valid, wb_dest, wb_data,
        output rd_data, rd_pend, iss_ready, idle, sb_err
    );
endinterface

// File: rtl/regfile_sb_cnt.sv
// Pending-write counter for one register; saturation is prevented upstream by iss_ready.
module regfile_sb_cnt
    import regfile_sb_pkg::*;
#(
    parameter int MAX_INFL = DEF_MAX_INFL,
    parameter int CW       = calc_cw(MAX_INFL)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          sat,
    output logic          zero
);
    logic [CW-1:0] cnt_reg;

    // A same-cycle issue and retire cancel, even when the count is already zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else if (inc && !dec) begin
            cnt_reg <= cnt_reg + CW'(1);
        end else if (!inc && dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign cnt  = cnt_reg;
    assign sat  = (cnt_reg == CW'(MAX_INFL));
    assign zero = (cnt_reg == '0);
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register pending-write scoreboard and writeback bypass.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NREG     = DEF_NREG,
    parameter int NRD      = DEF_NRD,
    parameter int MAX_INFL = DEF_MAX_INFL
) (
    input  logic        clk,
    input  logic        resetn,
    regfile_sb_if.slave bus
);
    localparam int AW = calc_aw(NREG);
    localparam int CW = calc_cw(MAX_INFL);
    localparam logic [AW-1:0] ZERO = AW'(REG_ZERO);

    logic [DATA_W-1:0] mem_reg [NREG];
    logic [CW-1:0]     cnt [NREG];
    logic [NREG-1:0]   sat, zero, inc, dec;
    logic              sb_err_reg;
    logic              iss_fire, wb_hit_iss, wb_byp;
    logic [DATA_W-1:0] rd_word [NRD];

    assign wb_hit_iss    = bus.wb_valid & (bus.wb_dest == bus.iss_dest);
    assign bus.iss_ready = (bus.iss_dest == ZERO) | ~sat[bus.iss_dest] | wb_hit_iss;
    assign iss_fire      = bus.iss_valid & bus.iss_ready;
    assign wb_byp        = bus.wb_valid & resetn;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == REG_ZERO) begin : g_r0
                assign cnt[gi]  = '0;
                assign sat[gi]  = 1'b0;
                assign zero[gi] = 1'b1;
                assign inc[gi]  = 1'b0;
                assign dec[gi]  = 1'b0;
            end else begin : g_rn
                assign inc[gi] = iss_fire & (bus.iss_dest == AW'(gi));
                assign dec[gi] = bus.wb_valid & (bus.wb_dest == AW'(gi));
                regfile_sb_cnt #(
                    .MAX_INFL (MAX_INFL),
                    .CW       (CW)
                ) u_cnt (
                    .clk    (clk),
                    .resetn (resetn),
                    .inc    (inc[gi]),
                    .dec    (dec[gi]),
                    .cnt    (cnt[gi]),
                    .sat    (sat[gi]),
                    .zero   (zero[gi])
                );
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NREG; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (bus.wb_valid && (bus.wb_dest != ZERO)) begin
            mem_reg[bus.wb_dest] <= bus.wb_data;
        end
    end

    // Retiring a write nobody issued points at a pipeline bug; the data still lands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sb_err_reg <= 1'b0;
        end else if (bus.wb_valid && (bus.wb_dest != ZERO) && zero[bus.wb_dest]) begin
            sb_err_reg <= 1'b1;
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] a;
            logic          hit;
            assign a   = bus.rd_addr[gi*AW +: AW];
            assign hit = wb_byp & (bus.wb_dest == a);
            assign rd_word[gi] = (a == ZERO) ? '0 : (hit ? bus.wb_data : mem_reg[a]);
            // A write retiring the last owed value clears the pend in the same cycle.
            assign bus.rd_pend[gi] = (a != ZERO) & ~zero[a] & ~(hit & (cnt[a] == CW'(1)));
        end
    endgenerate

    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W] = rd_word[i];
        end
    end

    assign bus.idle   = &zero;
    assign bus.sb_err = sb_err_reg;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: per-cycle compare against a behavioural model plus literal checks.
module tb_regfile_sb;
    localparam int DW  = 32;
    localparam int NR  = 32;
    localparam int ND  = 2;
    localparam int MX  = 3;
    localparam int AW  = 5;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic check_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    regfile_sb_if #(.DATA_W(DW), .NREG(NR), .NRD(ND)) bus ();

    regfile_sb #(.DATA_W(DW), .NREG(NR), .NRD(ND), .MAX_INFL(MX)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Behavioural state: register contents, outstanding-write counts, error flag.
    logic [DW-1:0] m_mem [NR];
    int            m_cnt [NR];
    logic          m_err;

    function automatic logic [AW-1:0] port_addr(input int p);
        return bus.rd_addr[p*AW +: AW];
    endfunction

    function automatic logic exp_ready();
        int d;
        d = int'(bus.iss_dest);
        return (d == 0) || (m_cnt[d] != MX) || (bus.wb_valid && bus.wb_dest == bus.iss_dest);
    endfunction

    function automatic logic [DW-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (resetn && bus.wb_valid && int'(bus.wb_dest) == a) return bus.wb_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_pend(input int a);
        if (a == 0 || m_cnt[a] == 0) return 1'b0;
        return !(bus.wb_valid && int'(bus.wb_dest) == a && m_cnt[a] == 1);
    endfunction

    function automatic logic exp_idle();
        for (int r = 0; r < NR; r++) if (m_cnt[r] != 0) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NR; r++) begin
                m_mem[r] <= '0;
                m_cnt[r] <= 0;
            end
            m_err <= 1'b0;
        end else begin
            automatic int  d    = int'(bus.iss_dest);
            automatic int  w    = int'(bus.wb_dest);
            automatic logic fire = bus.iss_valid && exp_ready() && d != 0;
            automatic logic wbn  = bus.wb_valid && w != 0;
            if (wbn) m_mem[w] <= bus.wb_data;
            if (wbn && m_cnt[w] == 0) m_err <= 1'b1;
            if (!(fire && wbn && d == w)) begin
                if (fire) m_cnt[d] <= m_cnt[d] + 1;
                if (wbn && m_cnt[w] > 0) m_cnt[w] <= m_cnt[w] - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int p = 0; p < ND; p++) begin
                automatic int a = int'(port_addr(p));
                chk($sformatf("cmp_rd_data%0d", p), 64'(bus.rd_data[p*DW +: DW]), 64'(exp_data(a)));
                chk($sformatf("cmp_rd_pend%0d", p), 64'(bus.rd_pend[p]), 64'(exp_pend(a)));
            end
            chk("cmp_iss_ready", 64'(bus.iss_ready), 64'(exp_ready()));
            chk("cmp_idle", 64'(bus.idle), 64'(exp_idle()));
            chk("cmp_sb_err", 64'(bus.sb_err), 64'(m_err));
        end
    end

    task automatic drive(input logic iv, input int id, input logic wv, input int wd,
                         input logic [DW-1:0] wdat, input int a0, input int a1);
        bus.iss_valid = iv;
        bus.iss_dest  = AW'(id);
        bus.wb_valid  = wv;
        bus.wb_dest   = AW'(wd);
        bus.wb_data   = wdat;
        bus.rd_addr   = {AW'(a1), AW'(a0)};
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 0, 1'b0, 0, '0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        drive(1'b0, 5, 1'b0, 0, '0, 5, 5);
        @(negedge clk);
        chk("rst_rd_data0", 64'(bus.rd_data[31:0]), 64'h0);
        chk("rst_iss_ready", 64'(bus.iss_ready), 64'h1);
        chk("rst_idle", 64'(bus.idle), 64'h1);
        cyc();
        resetn = 1'b1;

        @(negedge clk);
        chk("r5_rd_data1", 64'(bus.rd_data[63:32]), 64'h0);
        chk("r5_pend", 64'(bus.rd_pend), 64'h0);
        chk("r5_idle", 64'(bus.idle), 64'h1);
        chk("r5_ready", 64'(bus.iss_ready), 64'h1);

        drive(1'b1, 5, 1'b0, 0, '0, 5, 5);
        cyc();
        drive(1'b0, 5, 1'b0, 0, '0, 5, 5);
        @(negedge clk);
        chk("r5_pend_after_iss", 64'(bus.rd_pend), 64'h3);
        chk("r5_not_idle", 64'(bus.idle), 64'h0);
        cyc();
        drive(1'b0, 5, 1'b1, 5, 32'hDEADBEEF, 5, 5);
        @(negedge clk);
        chk("r5_bypass", 64'(bus.rd_data[31:0]), 64'hDEADBEEF);
        chk("r5_pend_wb", 64'(bus.rd_pend[0]), 64'h0);
        cyc();
        drive(1'b0, 5, 1'b0, 0, '0, 5, 5);
        @(negedge clk);
        chk("r5_idle_after_wb", 64'(bus.idle), 64'h1);
        chk("r5_mem", 64'(bus.rd_data[63:32]), 64'hDEADBEEF);

        drive(1'b1, 7, 1'b0, 0, '0, 7, 8);
        repeat (3) cyc();
        drive(1'b0, 7, 1'b0, 0, '0, 7, 8);
        @(negedge clk);
        chk("r7_sat_ready", 64'(bus.iss_ready), 64'h0);
        cyc();
        drive(1'b0, 8, 1'b0, 0, '0, 7, 8);
        @(negedge clk);
        chk("r8_ready", 64'(bus.iss_ready), 64'h1);
        cyc();
        drive(1'b1, 7, 1'b1, 7, 32'h77, 7, 8);
        @(negedge clk);
        chk("r7_wb_frees_slot", 64'(bus.iss_ready), 64'h1);
        cyc();
        drive(1'b0, 7, 1'b0, 0, '0, 7, 8);
        @(negedge clk);
        chk("r7_count_still3", 64'(bus.iss_ready), 64'h0);
        chk("r7_pend", 64'(bus.rd_pend[0]), 64'h1);
        cyc();

        drive(1'b1, 3, 1'b0, 0, '0, 3, 7);
        cyc();
        drive(1'b1, 3, 1'b1, 3, 32'h33, 3, 7);
        cyc();
        drive(1'b0, 3, 1'b0, 0, '0, 3, 7);
        @(negedge clk);
        chk("r3_pend_kept", 64'(bus.rd_pend[0]), 64'h1);
        cyc();
        drive(1'b0, 3, 1'b1, 3, 32'h34, 3, 7);
        @(negedge clk);
        chk("r3_pend_last_wb", 64'(bus.rd_pend[0]), 64'h0);
        cyc();

        drive(1'b1, 0, 1'b1, 0, 32'h1234, 0, 0);
        @(negedge clk);
        chk("r0_bypass_zero", 64'(bus.rd_data[31:0]), 64'h0);
        chk("r0_ready", 64'(bus.iss_ready), 64'h1);
        cyc();
        drive(1'b0, 0, 1'b0, 0, '0, 0, 9);
        @(negedge clk);
        chk("r0_read_zero", 64'(bus.rd_data[31:0]), 64'h0);
        chk("r0_no_err", 64'(bus.sb_err), 64'h0);
        cyc();
        drive(1'b0, 0, 1'b1, 9, 32'h99, 0, 9);
        @(negedge clk);
        chk("r9_bypass", 64'(bus.rd_data[63:32]), 64'h99);
        cyc();
        drive(1'b0, 0, 1'b0, 0, '0, 0, 9);
        @(negedge clk);
        chk("r9_err_set", 64'(bus.sb_err), 64'h1);
        chk("r9_written", 64'(bus.rd_data[63:32]), 64'h99);
        repeat (2) cyc();
        @(negedge clk);
        chk("r9_err_sticky", 64'(bus.sb_err), 64'h1);
        cyc();

        drive(1'b1, 4, 1'b0, 0, '0, 4, 5);
        repeat (2) cyc();
        drive(1'b0, 4, 1'b0, 0, '0, 4, 5);
        @(negedge clk);
        chk("r4_pend_before_rst", 64'(bus.rd_pend[0]), 64'h1);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_pend", 64'(bus.rd_pend), 64'h0);
        chk("arst_r4", 64'(bus.rd_data[31:0]), 64'h0);
        chk("arst_r5", 64'(bus.rd_data[63:32]), 64'h0);
        chk("arst_idle", 64'(bus.idle), 64'h1);
        chk("arst_err", 64'(bus.sb_err), 64'h0);
        repeat (2) cyc();
        resetn = 1'b1;
        drive(1'b1, 6, 1'b0, 0, '0, 6, 4);
        cyc();
        drive(1'b0, 6, 1'b1, 6, 32'hCAFE0006, 6, 4);
        @(negedge clk);
        chk("post_rst_bypass", 64'(bus.rd_data[31:0]), 64'hCAFE0006);
        cyc();
        drive(1'b0, 0, 1'b0, 0, '0, 6, 4);
        @(negedge clk);
        cyc();

        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
